// File: rtl/fpu_req_queue_pkg.sv
// rtl/fpu_req_queue_pkg.sv - shared opcodes, FSM states and default widths
package fpu_req_queue_pkg;

    localparam int DEF_W       = 32;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_OP_W    = 2;
    localparam int DEF_NUM_OPS = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } fpu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_e;

endpackage

// File: rtl/fpu_top.sv
// rtl/fpu_top.sv - single-precision core: latches on valid, pulses ready with the result one cycle later
module fpu_top
    import fpu_req_queue_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int OP_W = DEF_OP_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [W-1:0]    din1,
    input  logic [W-1:0]    din2,
    input  logic            valid,
    input  logic [OP_W-1:0] op_sel,
    output logic [W-1:0]    result,
    output logic            ready
);

    logic [W-1:0]    a_q, b_q;
    logic [OP_W-1:0] op_q;
    logic            stage_q;
    logic [W-1:0]    f_res;

    logic        sa, sb, sb_eff, sr;
    logic [7:0]  ea, eb, d;
    logic [23:0] ma, mb, mbig, msml, norm;
    logic [9:0]  er;
    logic [24:0] sum;
    logic [47:0] prod, quo;
    logic [4:0]  lz;
    logic [22:0] mr;
    logic        unused_bits;

    assign sa = a_q[31];
    assign sb = b_q[31];
    assign ea = a_q[30:23];
    assign eb = b_q[30:23];
    assign ma = {1'b1, a_q[22:0]};
    assign mb = {1'b1, b_q[22:0]};

    // Normal operands only, truncating rounding; zero inputs short-circuit to zero.
    always_comb begin
        sr = 1'b0; er = '0; mr = '0; sum = '0; prod = '0; quo = '0;
        lz = '0; norm = '0; mbig = '0; msml = '0; d = '0; sb_eff = 1'b0;
        case (op_q[1:0])
            OP_ADD, OP_SUB: begin
                sb_eff = sb ^ (op_q[1:0] == OP_SUB);
                if ({ea, ma} >= {eb, mb}) begin
                    sr = sa; er = {2'b0, ea}; mbig = ma; msml = mb; d = ea - eb;
                end else begin
                    sr = sb_eff; er = {2'b0, eb}; mbig = mb; msml = ma; d = eb - ea;
                end
                msml = (d > 8'd23) ? '0 : (msml >> d);
                sum  = (sa ^ sb_eff) ? ({1'b0, mbig} - {1'b0, msml})
                                     : ({1'b0, mbig} + {1'b0, msml});
                if (sum[24]) begin
                    mr = sum[23:1];
                    er = er + 10'd1;
                end else begin
                    for (int i = 0; i < 24; i++)
                        if (sum[i]) lz = 5'(23 - i);
                    norm = sum[23:0] << lz;
                    mr   = norm[22:0];
                    er   = er - {5'b0, lz};
                end
                if (sum == '0) begin sr = 1'b0; er = '0; mr = '0; end
            end
            OP_MUL: begin
                sr   = sa ^ sb;
                prod = {24'b0, ma} * {24'b0, mb};
                er   = {2'b0, ea} + {2'b0, eb} - 10'd127;
                if (prod[47]) begin
                    mr = prod[46:24];
                    er = er + 10'd1;
                end else begin
                    mr = prod[45:23];
                end
                if (ea == 8'd0 || eb == 8'd0) begin sr = 1'b0; er = '0; mr = '0; end
            end
            OP_DIV: begin
                sr  = sa ^ sb;
                quo = {ma, 24'b0} / {24'b0, mb};
                er  = {2'b0, ea} - {2'b0, eb} + 10'd126;
                if (quo[24]) begin
                    mr = quo[23:1];
                    er = er + 10'd1;
                end else begin
                    mr = quo[22:0];
                end
                if (ea == 8'd0) begin sr = 1'b0; er = '0; mr = '0; end
            end
            default: ;
        endcase
    end

    assign f_res       = W'({sr, er[7:0], mr});
    assign unused_bits = ^{er[9:8], prod[22:0], quo[47:25], norm[23]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            stage_q <= 1'b0;
            ready   <= 1'b0;
            result  <= '0;
        end else begin
            stage_q <= valid;
            ready   <= stage_q;
            if (valid) begin
                a_q  <= din1;
                b_q  <= din2;
                op_q <= op_sel;
            end
            if (stage_q) result <= f_res;
        end
    end

endmodule

// File: rtl/fpu_req_queue.sv
// rtl/fpu_req_queue.sv - in-order request FIFO and issue FSM in front of the fpu_top core
module fpu_req_queue
    import fpu_req_queue_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int OP_W    = DEF_OP_W,
    parameter int NUM_OPS = DEF_NUM_OPS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    din1,
    input  logic [W-1:0]    din2,
    input  logic [OP_W-1:0] op_sel,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    result,
    output logic            out_err,
    output logic            busy,
    output logic [15:0]     ops_done
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [OP_W-1:0] op;
    } req_t;

    req_t          mem [DEPTH];
    req_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          ready_en, full, empty, push, pop, head_legal, dispatch;
    state_e        state;
    logic          core_valid, core_ready;
    logic [W-1:0]  core_result;

    assign full       = (count == (AW+1)'(DEPTH));
    assign empty      = (count == '0);
    assign in_ready   = ready_en && !full && !flush;
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr];
    assign head_legal = ({1'b0, head.op} < (OP_W+1)'(NUM_OPS));
    // Dispatch is held off during flush so the FSM never picks up an entry being discarded.
    assign dispatch   = (state == IDLE) && !empty && !flush;
    assign pop        = (state == ISSUE) || (dispatch && !head_legal);
    assign busy       = !empty || (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {din1, din2, op_sel};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            core_valid <= 1'b0;
            out_valid  <= 1'b0;
            result     <= '0;
            out_err    <= 1'b0;
            ops_done   <= '0;
        end else begin
            core_valid <= 1'b0;
            case (state)
                IDLE: if (dispatch) begin
                    if (head_legal) begin
                        state      <= ISSUE;
                        core_valid <= 1'b1;
                    end else begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        result    <= '0;
                        out_err   <= 1'b1;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: if (core_ready) begin
                    state     <= HOLD;
                    out_valid <= 1'b1;
                    result    <= core_result;
                    out_err   <= 1'b0;
                end
                HOLD: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    if (ops_done != 16'hFFFF) ops_done <= ops_done + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fpu_top #(
        .W    (W),
        .OP_W (OP_W)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .din1   (head.a),
        .din2   (head.b),
        .valid  (core_valid),
        .op_sel (head.op),
        .result (core_result),
        .ready  (core_ready)
    );

endmodule

// File: tb/tb_fpu_req_queue.sv
// tb/tb_fpu_req_queue.sv - directed bench for fpu_req_queue
module tb_fpu_req_queue;
    import fpu_req_queue_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, flush, out_valid, out_ready, out_err, busy;
    logic [31:0] din1, din2, result;
    logic [1:0]  op_sel;
    logic [15:0] ops_done;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_err, b_busy;
    logic [31:0] b_result;
    logic [15:0] b_ops_done;
    logic        b_core_pulse = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int exp_ops = 0;

    logic [31:0] fa [5];
    logic [31:0] fb [5];
    logic [31:0] fr [5];
    logic [1:0]  fo [5];

    fpu_req_queue u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .din1(din1), .din2(din2), .op_sel(op_sel), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_err(out_err), .busy(busy), .ops_done(ops_done)
    );

    fpu_req_queue #(.NUM_OPS(3)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .din1(din1), .din2(din2), .op_sel(op_sel), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .result(b_result),
        .out_err(b_out_err), .busy(b_busy), .ops_done(b_ops_done)
    );

    always @(posedge clk) if (u_b.core_valid) b_core_pulse <= 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        din1 = a; din2 = b; op_sel = op; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(out_valid), 1);
    endtask

    initial begin
        int got;
        int n;
        fa[0] = 32'h3F800000; fb[0] = 32'h40000000; fo[0] = OP_ADD; fr[0] = 32'h40400000;
        fa[1] = 32'h40400000; fb[1] = 32'h3F800000; fo[1] = OP_SUB; fr[1] = 32'h40000000;
        fa[2] = 32'h40000000; fb[2] = 32'h40400000; fo[2] = OP_MUL; fr[2] = 32'h40C00000;
        fa[3] = 32'h40C00000; fb[3] = 32'h40000000; fo[3] = OP_DIV; fr[3] = 32'h40400000;
        fa[4] = 32'h40000000; fb[4] = 32'h40000000; fo[4] = OP_ADD; fr[4] = 32'h40800000;

        reset = 1'b1; in_valid = 1'b0; b_in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        din1 = '0; din2 = '0; op_sel = '0;
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_result", result, 0);
        check("rst_out_err", 32'(out_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ops_done", 32'(ops_done), 0);
        reset = 1'b0;
        #1;
        check("rel_in_ready_pre_edge", 32'(in_ready), 0);
        tick();
        check("rel_in_ready_post_edge", 32'(in_ready), 1);

        // Add scenario with latency: out_valid rises on the 4th edge after the push
        out_ready = 1'b1;
        push(32'h3F800000, 32'h40000000, OP_ADD);
        check("add_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            check("add_latency_low", 32'(out_valid), 0);
            tick();
        end
        check("add_out_valid", 32'(out_valid), 1);
        check("add_result", result, 32'h40400000);
        check("add_out_err", 32'(out_err), 0);
        tick();
        exp_ops++;
        check("add_ops_done", 32'(ops_done), 32'(exp_ops));
        check("add_out_valid_drop", 32'(out_valid), 0);
        check("add_idle_busy", 32'(busy), 0);

        // Illegal opcode on the NUM_OPS=3 instance
        din1 = 32'h3F800000; din2 = 32'h3F800000; op_sel = 2'd3; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        tick();
        check("ill_out_valid", 32'(b_out_valid), 1);
        check("ill_result", b_result, 0);
        check("ill_out_err", 32'(b_out_err), 1);
        tick();
        check("ill_ops_done", 32'(b_ops_done), 1);
        check("ill_out_valid_drop", 32'(b_out_valid), 0);
        check("ill_core_valid_never", 32'(b_core_pulse), 0);

        // Fill: 5 back-to-back pushes with the consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("fill_in_ready", 32'(in_ready), 1);
            push(fa[i], fb[i], fo[i]);
        end
        check("fill_full_in_ready", 32'(in_ready), 0);
        check("fill_hold_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        got = 0;
        n = 0;
        while (got < 5 && n < 60) begin
            if (out_valid) begin
                check("fill_result", result, fr[got]);
                check("fill_out_err", 32'(out_err), 0);
                got++;
            end
            tick();
            n++;
        end
        check("fill_count", 32'(got), 5);
        exp_ops += 5;
        check("fill_ops_done", 32'(ops_done), 32'(exp_ops));

        // Flush while the first request waits on the core; simultaneous push is refused
        push(32'h3F800000, 32'h40000000, OP_ADD);
        push(32'h40000000, 32'h40400000, OP_MUL);
        push(32'h40400000, 32'h3F800000, OP_SUB);
        din1 = 32'h40000000; din2 = 32'h40000000; op_sel = OP_ADD;
        in_valid = 1'b1; flush = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 0);
        tick();
        in_valid = 1'b0; flush = 1'b0;
        got = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) begin
                check("flush_result", result, 32'h40400000);
                got++;
            end
            tick();
        end
        check("flush_count", 32'(got), 1);
        check("flush_busy", 32'(busy), 0);
        exp_ops++;
        check("flush_ops_done", 32'(ops_done), 32'(exp_ops));

        // Back-pressure: 10 stalled cycles in HOLD
        out_ready = 1'b0;
        push(32'h40400000, 32'h3F800000, OP_SUB);
        wait_out("bp_wait");
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_result", result, 32'h40000000);
            check("bp_out_err", 32'(out_err), 0);
            check("bp_ops_done", 32'(ops_done), 32'(exp_ops));
            tick();
        end
        out_ready = 1'b1;
        tick();
        exp_ops++;
        check("bp_ops_done_after", 32'(ops_done), 32'(exp_ops));

        // Reset during WAIT
        push(32'h40000000, 32'h40000000, OP_ADD);
        tick();
        tick();
        reset = 1'b1;
        #1;
        exp_ops = 0;
        check("mrst_out_valid", 32'(out_valid), 0);
        check("mrst_result", result, 0);
        check("mrst_out_err", 32'(out_err), 0);
        check("mrst_ops_done", 32'(ops_done), 32'(exp_ops));
        check("mrst_busy", 32'(busy), 0);
        check("mrst_in_ready", 32'(in_ready), 0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mrst_late_valid", 32'(out_valid), 0);
            check("mrst_late_busy", 32'(busy), 0);
        end
        out_ready = 1'b0;
        push(32'h40000000, 32'h40400000, OP_MUL);
        wait_out("mrst_fresh_wait");
        check("mrst_fresh_result", result, 32'h40C00000);
        check("mrst_fresh_err", 32'(out_err), 0);
        out_ready = 1'b1;
        tick();
        exp_ops++;
        check("mrst_fresh_ops_done", 32'(ops_done), 32'(exp_ops));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
